// File: rtl/mouse_packet_decoder_if.sv
// Mouse link bundle: serial bit strobes in from the sampling front end,
// decoded position/button/status out to the application logic.
// Optional Y axis enabled by defining MOUSE_PACKET_DECODER_Y_EN.
interface mouse_packet_decoder_if #(
    parameter int WIDTH = 16
);
    logic             bit_valid;
    logic             bit_data;
    logic [WIDTH-1:0] mouse_x;
`ifdef MOUSE_PACKET_DECODER_Y_EN
    logic [WIDTH-1:0] mouse_y;
`endif
    logic             mouse_pressed_;
    logic             update;
    logic             frame_error;

    // Front end / application side: drives strobes, observes decoded outputs.
    modport master (
`ifdef MOUSE_PACKET_DECODER_Y_EN
        input  mouse_y,
`endif
        output bit_valid,
        output bit_data,
        input  mouse_x,
        input  mouse_pressed_,
        input  update,
        input  frame_error
    );

    // Decoder side.
    modport slave (
`ifdef MOUSE_PACKET_DECODER_Y_EN
        output mouse_y,
`endif
        input  bit_valid,
        input  bit_data,
        output mouse_x,
        output mouse_pressed_,
        output update,
        output frame_error
    );
endinterface

// File: rtl/mouse_packet_decoder.sv
// PS/2-style mouse packet decoder: 11-bit byte frames (start, 8 data LSB
// first, odd parity, stop) assembled into 3-byte packets; X delta is
// accumulated into a clamped absolute position.
// Optional Y axis enabled by defining MOUSE_PACKET_DECODER_Y_EN.
//
// state  | meaning
// -------+------------------------------------------------
// IDLE   | line idle, waiting for a 0 start bit
// DATA   | shifting in the 8 data bits
// PARITY | next strobe is the parity bit
// STOP   | next strobe is the stop bit; byte accepted or rejected
module mouse_packet_decoder #(
    parameter int WIDTH   = 16,
    parameter int MAX_X   = 639,
`ifdef MOUSE_PACKET_DECODER_Y_EN
    parameter int MAX_Y   = 479,
`endif
    parameter int TIMEOUT = 1024
) (
    input  logic                    clock,
    input  logic                    reset_,
    mouse_packet_decoder_if.slave   bus
);
    localparam int CNT_W = $clog2(TIMEOUT);

    typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

    state_t           state, state_nxt;
    logic [2:0]       bit_cnt;
    logic [7:0]       shift_reg;
    logic             parity_ok;
    logic [1:0]       byte_idx;
    logic [CNT_W-1:0] tmo_cnt;

    logic             b0_btn, b0_xs, b0_xo;
    logic [7:0]       b1_dx;
`ifdef MOUSE_PACKET_DECODER_Y_EN
    logic             b0_ys, b0_yo;
`endif

    logic shift_en, parity_load, stop_seen, byte_ok, active, tmo_hit;

    // Position plus signed 9-bit delta at WIDTH+2 bits, clamped to 0..lim.
    function automatic logic [WIDTH-1:0] clamp_add(
        input logic [WIDTH-1:0] pos,
        input logic             sgn,
        input logic [7:0]       mag,
        input logic [WIDTH-1:0] lim
    );
        logic signed [WIDTH+1:0] sum;
        sum = $signed({2'b00, pos}) + $signed({{(WIDTH-7){sgn}}, sgn, mag});
        if (sum < 0)
            clamp_add = '0;
        else if (sum > $signed({2'b00, lim}))
            clamp_add = lim;
        else
            clamp_add = sum[WIDTH-1:0];
    endfunction

    assign active  = (state != IDLE) || (byte_idx != 2'd0);
    assign tmo_hit = active && !bus.bit_valid && (tmo_cnt == CNT_W'(TIMEOUT - 1));
    assign byte_ok = stop_seen && bus.bit_data && parity_ok;

    // State register.
    always_ff @(posedge clock or negedge reset_) begin
        if (!reset_)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    // Next-state and per-strobe control decode; only strobes move the FSM.
    always_comb begin
        state_nxt   = state;
        shift_en    = 1'b0;
        parity_load = 1'b0;
        stop_seen   = 1'b0;
        if (tmo_hit) begin
            state_nxt = IDLE;
        end else if (bus.bit_valid) begin
            case (state)
                IDLE:   if (!bus.bit_data) state_nxt = DATA;
                DATA: begin
                    shift_en = 1'b1;
                    if (bit_cnt == 3'd7) state_nxt = PARITY;
                end
                PARITY: begin
                    parity_load = 1'b1;
                    state_nxt   = STOP;
                end
                STOP: begin
                    stop_seen = 1'b1;
                    state_nxt = IDLE;
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    // Bit shifter, bit counter and latched parity result.
    always_ff @(posedge clock or negedge reset_) begin
        if (!reset_) begin
            bit_cnt   <= '0;
            shift_reg <= '0;
            parity_ok <= 1'b0;
        end else begin
            if (bus.bit_valid && state == IDLE)
                bit_cnt <= '0;
            if (shift_en) begin
                shift_reg <= {bus.bit_data, shift_reg[7:1]};
                bit_cnt   <= bit_cnt + 3'd1;
            end
            if (parity_load)
                parity_ok <= ^{shift_reg, bus.bit_data};
        end
    end

    // Inactivity timer: counts only while a frame or packet is in progress.
    always_ff @(posedge clock or negedge reset_) begin
        if (!reset_)
            tmo_cnt <= '0;
        else if (bus.bit_valid || !active || tmo_hit)
            tmo_cnt <= '0;
        else
            tmo_cnt <= tmo_cnt + 1'b1;
    end

    // Packet assembly, error/update pulses and registered outputs.
    always_ff @(posedge clock or negedge reset_) begin
        if (!reset_) begin
            byte_idx           <= 2'd0;
            b0_btn             <= 1'b0;
            b0_xs              <= 1'b0;
            b0_xo              <= 1'b0;
            b1_dx              <= '0;
            bus.mouse_x        <= '0;
            bus.mouse_pressed_ <= 1'b0;
            bus.update         <= 1'b0;
            bus.frame_error    <= 1'b0;
`ifdef MOUSE_PACKET_DECODER_Y_EN
            b0_ys              <= 1'b0;
            b0_yo              <= 1'b0;
            bus.mouse_y        <= '0;
`endif
        end else begin
            bus.update      <= 1'b0;
            bus.frame_error <= 1'b0;
            if (tmo_hit) begin
                byte_idx        <= 2'd0;
                bus.frame_error <= 1'b1;
            end else if (stop_seen) begin
                if (!byte_ok) begin
                    byte_idx        <= 2'd0;
                    bus.frame_error <= 1'b1;
                end else begin
                    case (byte_idx)
                        2'd0: begin
                            // Status byte must carry the sync bit to start a packet.
                            if (shift_reg[3]) begin
                                b0_btn   <= shift_reg[0];
                                b0_xs    <= shift_reg[4];
                                b0_xo    <= shift_reg[6];
`ifdef MOUSE_PACKET_DECODER_Y_EN
                                b0_ys    <= shift_reg[5];
                                b0_yo    <= shift_reg[7];
`endif
                                byte_idx <= 2'd1;
                            end else begin
                                bus.frame_error <= 1'b1;
                            end
                        end
                        2'd1: begin
                            b1_dx    <= shift_reg;
                            byte_idx <= 2'd2;
                        end
                        2'd2: begin
                            byte_idx           <= 2'd0;
                            bus.update         <= 1'b1;
                            bus.mouse_pressed_ <= b0_btn;
                            if (!b0_xo)
                                bus.mouse_x <= clamp_add(bus.mouse_x, b0_xs, b1_dx, WIDTH'(MAX_X));
`ifdef MOUSE_PACKET_DECODER_Y_EN
                            if (!b0_yo)
                                bus.mouse_y <= clamp_add(bus.mouse_y, b0_ys, shift_reg, WIDTH'(MAX_Y));
`endif
                        end
                        default: byte_idx <= 2'd0;
                    endcase
                end
            end
        end
    end
endmodule

// File: tb/tb_mouse_packet_decoder.sv
// Directed bench for mouse_packet_decoder (default build, X axis only).
module tb_mouse_packet_decoder;
    logic clock;
    logic reset_;
    int   n_tests;
    int   n_failed;
    int   upd_pulses;
    int   err_pulses;
    int   upd_base;
    int   err_base;

    mouse_packet_decoder_if #(.WIDTH(16)) bus ();

    mouse_packet_decoder #(.WIDTH(16), .MAX_X(639), .TIMEOUT(1024)) dut (
        .clock  (clock),
        .reset_ (reset_),
        .bus    (bus.slave)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Pulse counters sampled on the falling edge, away from register updates.
    always @(negedge clock) begin
        if (bus.update)      upd_pulses = upd_pulses + 1;
        if (bus.frame_error) err_pulses = err_pulses + 1;
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_failed++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // One strobe per cycle; returns 1 time unit after the capturing edge.
    task automatic send_bit(input logic b);
        bus.bit_valid = 1'b1;
        bus.bit_data  = b;
        @(posedge clock);
        #1;
        bus.bit_valid = 1'b0;
        bus.bit_data  = 1'b1;
    endtask

    task automatic send_byte(input logic [7:0] d, input logic par_flip, input logic stop);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(d[i]);
        send_bit(~(^d) ^ par_flip);
        send_bit(stop);
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clock);
            #1;
        end
    endtask

    // Sends a good packet and checks the update pulse lands right after the last stop.
    task automatic send_packet(input string tag, input logic [7:0] b0, input logic [7:0] b1,
                               input logic [7:0] b2, input int exp_x, input logic exp_btn);
        upd_base = upd_pulses;
        err_base = err_pulses;
        send_byte(b0, 1'b0, 1'b1);
        idle_cycles(2);
        send_byte(b1, 1'b0, 1'b1);
        send_byte(b2, 1'b0, 1'b1);
        check_val({tag, "_update"}, 32'(bus.update), 32'd1);
        check_val({tag, "_ferr_low"}, 32'(bus.frame_error), 32'd0);
        check_val({tag, "_x"}, 32'(bus.mouse_x), 32'(exp_x));
        check_val({tag, "_btn"}, 32'(bus.mouse_pressed_), 32'(exp_btn));
        idle_cycles(3);
        check_val({tag, "_update_count"}, 32'(upd_pulses - upd_base), 32'd1);
        check_val({tag, "_err_count"}, 32'(err_pulses - err_base), 32'd0);
    endtask

    // Sends one bad byte and checks for a single error pulse and no update.
    task automatic send_bad(input string tag, input logic [7:0] d, input logic flip, input logic stop);
        upd_base = upd_pulses;
        err_base = err_pulses;
        send_byte(d, flip, stop);
        check_val({tag, "_ferr"}, 32'(bus.frame_error), 32'd1);
        check_val({tag, "_no_update"}, 32'(bus.update), 32'd0);
        idle_cycles(3);
        check_val({tag, "_err_count"}, 32'(err_pulses - err_base), 32'd1);
        check_val({tag, "_upd_count"}, 32'(upd_pulses - upd_base), 32'd0);
    endtask

    initial begin
        int first_err;
        int seen_err;
        n_tests    = 0;
        n_failed   = 0;
        upd_pulses = 0;
        err_pulses = 0;
        bus.bit_valid = 1'b0;
        bus.bit_data  = 1'b1;
        reset_ = 1'b0;
        idle_cycles(3);
        check_val("rst_x", 32'(bus.mouse_x), 32'd0);
        check_val("rst_btn", 32'(bus.mouse_pressed_), 32'd0);
        check_val("rst_update", 32'(bus.update), 32'd0);
        check_val("rst_ferr", 32'(bus.frame_error), 32'd0);
        reset_ = 1'b1;
        idle_cycles(2);

        // Idle-line ones are ignored.
        send_bit(1'b1);
        send_bit(1'b1);
        send_packet("pkt_basic", 8'h09, 8'h05, 8'h00, 5, 1'b1);
        send_packet("pkt_neg_clamp", 8'h18, 8'hF0, 8'h00, 0, 1'b0);
        send_packet("pkt_up255a", 8'h08, 8'hFF, 8'h00, 255, 1'b0);
        send_packet("pkt_up255b", 8'h08, 8'hFF, 8'h00, 510, 1'b0);
        send_packet("pkt_to630", 8'h08, 8'h78, 8'h00, 630, 1'b0);
        send_packet("pkt_max_clamp", 8'h08, 8'h20, 8'h00, 639, 1'b0);
        send_packet("pkt_overflow", 8'h48, 8'h7F, 8'h00, 639, 1'b0);

        send_bad("parity_err", 8'h09, 1'b1, 1'b1);
        send_packet("pkt_after_parity", 8'h19, 8'hFF, 8'h00, 638, 1'b1);

        send_bad("sync_err", 8'h01, 1'b0, 1'b1);
        send_packet("pkt_after_sync", 8'h18, 8'hFE, 8'h00, 636, 1'b0);

        send_bad("stop_err", 8'h08, 1'b0, 1'b0);
        // Stop error on the middle byte discards the partial packet.
        send_byte(8'h09, 1'b0, 1'b1);
        send_bad("stop_err_b1", 8'h05, 1'b0, 1'b0);
        send_packet("pkt_after_stop", 8'h09, 8'h01, 8'h00, 637, 1'b1);

        // Timeout after a lone status byte.
        upd_base  = upd_pulses;
        send_byte(8'h08, 1'b0, 1'b1);
        first_err = 0;
        seen_err  = 0;
        for (int i = 1; i <= 1100; i++) begin
            @(posedge clock);
            #1;
            if (bus.frame_error) begin
                seen_err++;
                if (first_err == 0) first_err = i;
            end
        end
        check_val("tmo_cycle", 32'(first_err), 32'd1024);
        check_val("tmo_once", 32'(seen_err), 32'd1);
        check_val("tmo_x_hold", 32'(bus.mouse_x), 32'd637);
        check_val("tmo_btn_hold", 32'(bus.mouse_pressed_), 32'd1);
        check_val("tmo_no_update", 32'(upd_pulses - upd_base), 32'd0);
        send_packet("pkt_after_tmo", 8'h18, 8'hFD, 8'h00, 634, 1'b0);
        send_packet("pkt_btn_again", 8'h09, 8'h00, 8'h00, 634, 1'b1);

        // Asynchronous reset in the middle of a byte.
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b0);
        #2;
        reset_ = 1'b0;
        #1;
        check_val("arst_x", 32'(bus.mouse_x), 32'd0);
        check_val("arst_btn", 32'(bus.mouse_pressed_), 32'd0);
        check_val("arst_update", 32'(bus.update), 32'd0);
        check_val("arst_ferr", 32'(bus.frame_error), 32'd0);
        idle_cycles(2);
        reset_ = 1'b1;
        idle_cycles(2);
        send_packet("pkt_after_arst", 8'h09, 8'h07, 8'h00, 7, 1'b1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_failed);
        $finish;
    end

    // Guard against a stuck run.
    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end
endmodule
